// File: rtl/de1_soc_qsys_cpu_div_pkg.sv
// Shared types and helpers for the iterative restoring divider cell.
package de1_soc_qsys_cpu_div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIXUP,
      DONE
   } div_state_t;

   // One extra bit keeps |-2^(WIDTH-1)| exact.
   function automatic logic [DIV_WIDTH:0] abs_w(input logic [DIV_WIDTH-1:0] value,
                                                input logic signed_en);
      logic [DIV_WIDTH:0] ext;
      ext = {value[DIV_WIDTH-1], value};
      if (signed_en && value[DIV_WIDTH-1])
         abs_w = -ext;
      else
         abs_w = {1'b0, value};
   endfunction

endpackage

// File: rtl/de1_soc_qsys_cpu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module de1_soc_qsys_cpu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividend_bit,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             qbit
);

   logic [WIDTH:0] trial;

   assign trial = {rem, dividend_bit};
   assign qbit  = (trial >= divisor);

   // When the subtraction succeeds the difference is below the divisor, so it fits WIDTH bits.
   assign next_rem = qbit ? (trial[WIDTH-1:0] - divisor[WIDTH-1:0]) : trial[WIDTH-1:0];

endmodule

// File: rtl/de1_soc_qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II custom datapath (quotient + remainder).
module de1_soc_qsys_cpu_div_cell
   import de1_soc_qsys_cpu_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] A_div_src1,
   input  logic [WIDTH-1:0] A_div_src2,
   input  logic             A_div_signed,
   input  logic             A_div_start,
   output logic             A_div_busy,
   output logic             A_div_done,
   output logic [WIDTH-1:0] A_div_quotient,
   output logic [WIDTH-1:0] A_div_remainder,
   output logic             A_div_by_zero
);

   div_state_t           state;
   div_state_t           next_state;
   logic [DIV_CNT_W-1:0] counter;
   logic [WIDTH-1:0]     dvd;
   logic [WIDTH:0]       dsr;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     src1_raw;
   logic                 neg_q;
   logic                 neg_r;
   logic                 zero_div;
   logic                 accept;
   logic [WIDTH-1:0]     dvd_mag;
   logic [WIDTH:0]       dsr_mag;
   logic [WIDTH-1:0]     step_rem;
   logic                 step_qbit;

   assign accept     = A_div_start && (state == IDLE || state == DONE);
   assign A_div_busy = (state == RUN) || (state == FIXUP);
   assign A_div_done = (state == DONE);

   // A WIDTH-bit magnitude is enough for the dividend: 2^(WIDTH-1) fits unsigned.
   assign dvd_mag = (A_div_signed && A_div_src1[WIDTH-1]) ? -A_div_src1 : A_div_src1;
   assign dsr_mag = abs_w(A_div_src2, A_div_signed);

   de1_soc_qsys_cpu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem          (rem),
      .dividend_bit (dvd[WIDTH-1]),
      .divisor      (dsr),
      .next_rem     (step_rem),
      .qbit         (step_qbit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = RUN;
         RUN:     if (counter == '0) next_state = FIXUP;
         FIXUP:   next_state = DONE;
         DONE:    next_state = accept ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The dividend register doubles as the quotient shift register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter         <= '0;
         dvd             <= '0;
         dsr             <= '0;
         rem             <= '0;
         src1_raw        <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         zero_div        <= 1'b0;
         A_div_quotient  <= '0;
         A_div_remainder <= '0;
         A_div_by_zero   <= 1'b0;
      end else if (accept) begin
         zero_div <= (A_div_src2 == '0);
         neg_q    <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
         neg_r    <= A_div_signed & A_div_src1[WIDTH-1];
         dvd      <= dvd_mag;
         dsr      <= dsr_mag;
         src1_raw <= A_div_src1;
         rem      <= '0;
         counter  <= DIV_CNT_W'(WIDTH - 1);
      end else if (state == RUN) begin
         rem <= step_rem;
         dvd <= {dvd[WIDTH-2:0], step_qbit};
         if (counter != '0)
            counter <= counter - 1'b1;
      end else if (state == FIXUP) begin
         A_div_by_zero <= zero_div;
         if (zero_div) begin
            A_div_quotient  <= '1;
            A_div_remainder <= src1_raw;
         end else begin
            A_div_quotient  <= neg_q ? -dvd : dvd;
            A_div_remainder <= neg_r ? -rem : rem;
         end
      end
   end

endmodule

// File: tb/tb_de1_soc_qsys_cpu_div_cell.sv
// Self-checking bench for the divider cell against a plain-arithmetic reference model.
module tb_de1_soc_qsys_cpu_div_cell;

   logic        clk;
   logic        reset_n;
   logic [31:0] A_div_src1;
   logic [31:0] A_div_src2;
   logic        A_div_signed;
   logic        A_div_start;
   logic        A_div_busy;
   logic        A_div_done;
   logic [31:0] A_div_quotient;
   logic [31:0] A_div_remainder;
   logic        A_div_by_zero;

   int total = 0;
   int bad   = 0;

   de1_soc_qsys_cpu_div_cell #(.WIDTH(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .A_div_src1      (A_div_src1),
      .A_div_src2      (A_div_src2),
      .A_div_signed    (A_div_signed),
      .A_div_start     (A_div_start),
      .A_div_busy      (A_div_busy),
      .A_div_done      (A_div_done),
      .A_div_quotient  (A_div_quotient),
      .A_div_remainder (A_div_remainder),
      .A_div_by_zero   (A_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: truncating division via 64-bit integer arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      longint sa;
      longint sb;
      z = (b == 32'd0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issue one start pulse, then count cycles until done (bounded).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output bit busy_ok);
      @(negedge clk);
      A_div_src1   = a;
      A_div_src2   = b;
      A_div_signed = sgn;
      A_div_start  = 1'b1;
      @(negedge clk);
      A_div_start  = 1'b0;
      A_div_src1   = $urandom;
      A_div_src2   = $urandom;
      A_div_signed = 1'($urandom);
      lat     = 1;
      busy_ok = 1'b1;
      while (A_div_done !== 1'b1 && lat < 100) begin
         if (A_div_busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (A_div_busy !== 1'b0) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      A_div_start  = 1'b1;
      A_div_src1   = 32'd9;
      A_div_src2   = 32'd3;
      A_div_signed = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({A_div_busy, A_div_done, A_div_by_zero, A_div_quotient, A_div_remainder} !== 67'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b z=%b q=%h r=%h, want all zero",
                  A_div_busy, A_div_done, A_div_by_zero, A_div_quotient, A_div_remainder);
      end
      A_div_start = 1'b0;
      reset_n     = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({A_div_busy, A_div_done} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, want 0 0", A_div_busy, A_div_done);
      end
   endtask

   task automatic test_unsigned();
      int lat;
      bit busy_ok;
      do_op(32'd100, 32'd7, 1'b0, lat, busy_ok);
      total++;
      if (lat !== 34) begin bad++; $display("[TB] FAIL u100_7_latency: got %0d want 34", lat); end
      total++;
      if (busy_ok !== 1'b1) begin bad++; $display("[TB] FAIL u100_7_busy: got busy_ok=%0d want 1", busy_ok); end
      total++;
      if (A_div_quotient !== 32'd14) begin bad++; $display("[TB] FAIL u100_7_q: got %0d want 14", A_div_quotient); end
      total++;
      if (A_div_remainder !== 32'd2) begin bad++; $display("[TB] FAIL u100_7_r: got %0d want 2", A_div_remainder); end
      total++;
      if (A_div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL u100_7_z: got %b want 0", A_div_by_zero); end
   endtask

   // Directed corner operands: signed signs, overflow, divide by zero.
   task automatic test_corners();
      logic [31:0] src1 [8] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000,
                                32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000};
      logic [31:0] src2 [8] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd0, 32'd0, 32'd0, 32'd1};
      logic        sgn  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] want_q [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] want_r [8] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000,
                                  32'd5, 32'd5, 32'hFFFF_FFFB, 32'd0};
      logic        want_z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int lat;
      bit busy_ok;
      for (int i = 0; i < 8; i++) begin
         do_op(src1[i], src2[i], sgn[i], lat, busy_ok);
         total++;
         if (lat !== 34 || busy_ok !== 1'b1) begin
            bad++;
            $display("[TB] FAIL corner%0d_timing: got lat=%0d busy_ok=%0d want 34 1", i, lat, busy_ok);
         end
         total++;
         if ({A_div_quotient, A_div_remainder, A_div_by_zero} !== {want_q[i], want_r[i], want_z[i]}) begin
            bad++;
            $display("[TB] FAIL corner%0d_result: got q=%h r=%h z=%b want q=%h r=%h z=%b", i,
                     A_div_quotient, A_div_remainder, A_div_by_zero, want_q[i], want_r[i], want_z[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, eq, er;
      logic        s, ez;
      int lat;
      bit busy_ok;
      for (int i = 0; i < 40; i++) begin
         a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 3));
            default: b = $urandom;
         endcase
         s = 1'($urandom);
         model(a, b, s, eq, er, ez);
         do_op(a, b, s, lat, busy_ok);
         total++;
         if ({A_div_quotient, A_div_remainder, A_div_by_zero} !== {eq, er, ez} || lat !== 34) begin
            bad++;
            $display("[TB] FAIL random%0d %h/%h s=%b: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=34",
                     i, a, b, s, A_div_quotient, A_div_remainder, A_div_by_zero, lat, eq, er, ez);
         end
      end
   endtask

   task automatic test_ignored_start();
      int cyc;
      @(negedge clk);
      A_div_src1 = 32'd1000; A_div_src2 = 32'd3; A_div_signed = 1'b0; A_div_start = 1'b1;
      @(negedge clk);
      A_div_start = 1'b0;
      cyc = 1;
      while (A_div_done !== 1'b1 && cyc < 100) begin
         if (cyc == 10) begin
            A_div_src1 = 32'd77; A_div_src2 = 32'd5; A_div_start = 1'b1;
         end else begin
            A_div_start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      A_div_start = 1'b0;
      total++;
      if (cyc !== 34) begin bad++; $display("[TB] FAIL ignored_start_latency: got %0d want 34", cyc); end
      total++;
      if ({A_div_quotient, A_div_remainder} !== {32'd333, 32'd1}) begin
         bad++;
         $display("[TB] FAIL ignored_start_result: got q=%0d r=%0d want q=333 r=1", A_div_quotient, A_div_remainder);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit hold_ok;
      logic [31:0] q1, r1, q2, r2;
      logic        z1, z2;
      model(32'hFFFF_FF9C, 32'd7, 1'b1, q1, r1, z1);
      model(32'd12345, 32'd100, 1'b0, q2, r2, z2);
      @(negedge clk);
      A_div_src1 = 32'hFFFF_FF9C; A_div_src2 = 32'd7; A_div_signed = 1'b1; A_div_start = 1'b1;
      @(negedge clk);
      A_div_start = 1'b0;
      cyc = 1;
      while (A_div_done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (cyc !== 34 || A_div_quotient !== q1 || A_div_remainder !== r1) begin
         bad++;
         $display("[TB] FAIL b2b_first: got cyc=%0d q=%h r=%h want cyc=34 q=%h r=%h",
                  cyc, A_div_quotient, A_div_remainder, q1, r1);
      end
      A_div_src1 = 32'd12345; A_div_src2 = 32'd100; A_div_signed = 1'b0; A_div_start = 1'b1;
      @(negedge clk);
      A_div_start = 1'b0;
      cyc++;
      hold_ok = 1'b1;
      while (A_div_done !== 1'b1 && cyc < 150) begin
         if (A_div_quotient !== q1 || A_div_remainder !== r1 || A_div_busy !== 1'b1) hold_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (cyc !== 68) begin bad++; $display("[TB] FAIL b2b_second_latency: got %0d want 68", cyc); end
      total++;
      if (hold_ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_hold: got hold_ok=%0d want 1", hold_ok); end
      total++;
      if ({A_div_quotient, A_div_remainder, A_div_by_zero} !== {q2, r2, z2}) begin
         bad++;
         $display("[TB] FAIL b2b_second_result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                  A_div_quotient, A_div_remainder, A_div_by_zero, q2, r2, z2);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int spurious;
      int lat;
      bit busy_ok;
      @(negedge clk);
      A_div_src1 = 32'd999; A_div_src2 = 32'd10; A_div_signed = 1'b0; A_div_start = 1'b1;
      @(negedge clk);
      A_div_start = 1'b0;
      for (cyc = 1; cyc < 15; cyc++) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({A_div_busy, A_div_done, A_div_by_zero, A_div_quotient, A_div_remainder} !== 67'd0) begin
         bad++;
         $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b z=%b q=%h r=%h, want all zero",
                  A_div_busy, A_div_done, A_div_by_zero, A_div_quotient, A_div_remainder);
      end
      @(negedge clk);
      reset_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (A_div_done !== 1'b0 || A_div_busy !== 1'b0) spurious++;
      end
      total++;
      if (spurious !== 0) begin bad++; $display("[TB] FAIL reset_mid_quiet: got %0d active cycles want 0", spurious); end
      do_op(32'd999, 32'd10, 1'b0, lat, busy_ok);
      total++;
      if (lat !== 34 || A_div_quotient !== 32'd99 || A_div_remainder !== 32'd9) begin
         bad++;
         $display("[TB] FAIL reset_mid_recover: got lat=%0d q=%0d r=%0d want lat=34 q=99 r=9",
                  lat, A_div_quotient, A_div_remainder);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_corners();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
